// File: rtl/nx_node_loader_if.sv
// Message-in / load-out bundle between the node router, nx_node_loader and the node core.
interface nx_node_loader_if #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned REG_W = 16,
  parameter int unsigned IO_W  = 4,
  parameter int unsigned SLOTS = 32
);
  localparam int unsigned INST_W = OP_W + 3 * $clog2(REG_W) + 1 + $clog2(IO_W);
  localparam int unsigned MSG_W  = INST_W + 2;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned IDX_W  = $clog2(IO_W);

  logic [MSG_W-1:0]  msg_data;
  logic              msg_valid;
  logic              msg_ready;
  logic [INST_W-1:0] load_instr;
  logic [SLOT_W-1:0] load_slot;
  logic              load_last;
  logic              load_valid;
  logic              in_value;
  logic [IDX_W-1:0]  in_index;
  logic              in_valid;

  modport slave (
    input  msg_data, msg_valid,
    output msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid
  );

  modport master (
    output msg_data, msg_valid,
    input  msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid
  );
endinterface

// File: rtl/nx_node_loader.sv
// Decodes router messages into node-core instruction and input loads.
// Optional NX_LOADER_ERR_EN builds the sticky drop flag and saturating drop counter.
module nx_node_loader #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned REG_W = 16,
  parameter int unsigned IO_W  = 4,
  parameter int unsigned SLOTS = 32
) (
  input  logic             clk,
  input  logic             rst,
  nx_node_loader_if.slave  bus,
  output logic             loaded,
  output logic             err,
  output logic [7:0]       err_count
);
  localparam int unsigned INST_W = OP_W + 3 * $clog2(REG_W) + 1 + $clog2(IO_W);
  localparam int unsigned MSG_W  = INST_W + 2;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned IDX_W  = $clog2(IO_W);

  typedef enum logic [1:0] {
    MSG_INSTR      = 2'b00,
    MSG_INSTR_LAST = 2'b01,
    MSG_INPUT      = 2'b10,
    MSG_NOP        = 2'b11
  } msg_type_e;

  typedef enum logic {
    LOADING = 1'b0,
    LOADED  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic              ready_q, ready_d;
  logic [INST_W-1:0] load_instr_q, load_instr_d;
  logic [SLOT_W-1:0] load_slot_q, load_slot_d;
  logic              load_last_q, load_last_d;
  logic              load_valid_q, load_valid_d;
  logic              in_value_q, in_value_d;
  logic [IDX_W-1:0]  in_index_q, in_index_d;
  logic              in_valid_q, in_valid_d;
  logic              loaded_q, loaded_d;

  logic              accept_c;
  msg_type_e         msg_type_c;
  logic [INST_W-1:0] payload_c;

  // ready stays low through the deassert edge, so a message presented there is ignored
  assign accept_c   = bus.msg_valid & ready_q;
  assign msg_type_c = msg_type_e'(bus.msg_data[MSG_W-1 -: 2]);
  assign payload_c  = bus.msg_data[INST_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOADING;
      slot_cnt_q   <= '0;
      ready_q      <= 1'b0;
      load_instr_q <= '0;
      load_slot_q  <= '0;
      load_last_q  <= 1'b0;
      load_valid_q <= 1'b0;
      in_value_q   <= 1'b0;
      in_index_q   <= '0;
      in_valid_q   <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      ready_q      <= ready_d;
      load_instr_q <= load_instr_d;
      load_slot_q  <= load_slot_d;
      load_last_q  <= load_last_d;
      load_valid_q <= load_valid_d;
      in_value_q   <= in_value_d;
      in_index_q   <= in_index_d;
      in_valid_q   <= in_valid_d;
      loaded_q     <= loaded_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    ready_d      = 1'b1;
    load_instr_d = load_instr_q;
    load_slot_d  = load_slot_q;
    load_last_d  = load_last_q;
    load_valid_d = 1'b0;
    in_value_d   = in_value_q;
    in_index_d   = in_index_q;
    in_valid_d   = 1'b0;

    if (accept_c) begin
      case (msg_type_c)
        MSG_INSTR, MSG_INSTR_LAST: begin
          // late instructions are discarded; the counter never wraps past the last slot
          if (state_q == LOADING) begin
            load_valid_d = 1'b1;
            load_instr_d = payload_c;
            load_slot_d  = slot_cnt_q;
            load_last_d  = (msg_type_c == MSG_INSTR_LAST) ||
                           (slot_cnt_q == SLOT_W'(SLOTS - 1));
            if (load_last_d) state_d = LOADED;
            else             slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          end
        end
        MSG_INPUT: begin
          in_valid_d = 1'b1;
          in_index_d = payload_c[IDX_W:1];
          in_value_d = payload_c[0];
        end
        default: ;
      endcase
    end

    loaded_d = (state_d == LOADED);
  end

  assign bus.msg_ready  = ready_q;
  assign bus.load_instr = load_instr_q;
  assign bus.load_slot  = load_slot_q;
  assign bus.load_last  = load_last_q;
  assign bus.load_valid = load_valid_q;
  assign bus.in_value   = in_value_q;
  assign bus.in_index   = in_index_q;
  assign bus.in_valid   = in_valid_q;
  assign loaded         = loaded_q;

`ifdef NX_LOADER_ERR_EN
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;
  logic       drop_c;

  // instruction types have a zero header MSB
  assign drop_c = accept_c && (state_q == LOADED) && !bus.msg_data[MSG_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    err_d       = err_q | drop_c;
    err_count_d = err_count_q;
    if (drop_c && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  assign err       = err_q;
  assign err_count = err_count_q;
`else
  assign err       = 1'b0;
  assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_nx_node_loader.sv
// Directed and randomized checks of nx_node_loader against a message-level reference model.
module tb_nx_node_loader;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned IO_W   = 4;
  localparam int unsigned SLOTS  = 32;
  localparam int unsigned INST_W = OP_W + 3 * $clog2(REG_W) + 1 + $clog2(IO_W);

  localparam logic [1:0] T_INSTR = 2'b00;
  localparam logic [1:0] T_LAST  = 2'b01;
  localparam logic [1:0] T_INPUT = 2'b10;
  localparam logic [1:0] T_NOP   = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       loaded;
  logic       err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // reference model: program progress, drop tally, and what the outputs should show now
  int                m_slot;
  bit                m_loaded;
  int                m_drops;
  bit                e_ready;
  bit                e_lv;
  bit                e_iv;
  logic [INST_W-1:0] e_instr;
  int                e_slot;
  bit                e_last;
  int                e_idx;
  bit                e_val;

  always #5 clk = ~clk;

  nx_node_loader_if #(.OP_W(OP_W), .REG_W(REG_W), .IO_W(IO_W), .SLOTS(SLOTS)) bus ();

  nx_node_loader #(.OP_W(OP_W), .REG_W(REG_W), .IO_W(IO_W), .SLOTS(SLOTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .loaded    (loaded),
    .err       (err),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int exp_cnt;
    bit exp_err;
`ifdef NX_LOADER_ERR_EN
    exp_err = (m_drops > 0);
    exp_cnt = (m_drops > 255) ? 255 : m_drops;
`else
    exp_err = 1'b0;
    exp_cnt = 0;
`endif
    chk("msg_ready",  32'(bus.msg_ready),  32'(e_ready));
    chk("load_valid", 32'(bus.load_valid), 32'(e_lv));
    chk("in_valid",   32'(bus.in_valid),   32'(e_iv));
    chk("load_instr", 32'(bus.load_instr), 32'(e_instr));
    chk("load_slot",  32'(bus.load_slot),  32'(e_slot));
    chk("load_last",  32'(bus.load_last),  32'(e_last));
    chk("in_index",   32'(bus.in_index),   32'(e_idx));
    chk("in_value",   32'(bus.in_value),   32'(e_val));
    chk("loaded",     32'(loaded),         32'(m_loaded));
    chk("err",        32'(err),            32'(exp_err));
    chk("err_count",  32'(err_count),      32'(exp_cnt));
  endtask

  // present one message for the coming edge and predict its effect
  task automatic drive(input bit v, input logic [1:0] t, input logic [INST_W-1:0] p);
    bus.msg_valid = v;
    bus.msg_data  = {t, p};
    e_lv = 1'b0;
    e_iv = 1'b0;
    if (v && e_ready) begin
      if (t == T_INSTR || t == T_LAST) begin
        if (!m_loaded) begin
          e_lv    = 1'b1;
          e_instr = p;
          e_slot  = m_slot;
          e_last  = (t == T_LAST) || (m_slot == SLOTS - 1);
          if (e_last) m_loaded = 1'b1;
          else        m_slot   = m_slot + 1;
        end else begin
          m_drops = m_drops + 1;
        end
      end else if (t == T_INPUT) begin
        e_iv  = 1'b1;
        e_idx = int'((p >> 1) % IO_W);
        e_val = p[0];
      end
    end
    e_ready = 1'b1;
  endtask

  task automatic step(input bit v, input logic [1:0] t, input logic [INST_W-1:0] p);
    @(negedge clk);
    check_all();
    drive(v, t, p);
  endtask

  task automatic model_reset();
    m_slot   = 0;
    m_loaded = 1'b0;
    m_drops  = 0;
    e_ready  = 1'b0;
    e_lv     = 1'b0;
    e_iv     = 1'b0;
    e_instr  = '0;
    e_slot   = 0;
    e_last   = 1'b0;
    e_idx    = 0;
    e_val    = 1'b0;
  endtask

  // release drives an INSTR on the deassert edge, which must be ignored
  task automatic do_reset();
    rst           = 1'b1;
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, T_INSTR, INST_W'($urandom()));
  endtask

  initial begin
    logic [1:0]        rt;
    logic [INST_W-1:0] rp;

    do_reset();

    step(1'b1, T_INSTR, INST_W'(32'h00011));
    step(1'b1, T_INSTR, INST_W'(32'h00022));
    step(1'b1, T_INSTR, INST_W'(32'h00033));
    step(1'b1, T_LAST,  INST_W'(32'h00044));
    step(1'b1, T_INPUT, INST_W'(32'h5));
    step(1'b1, T_INPUT, INST_W'(32'h4));
    step(1'b0, T_NOP,   '0);

    // slot overflow closes the program, the next instruction is dropped
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b1, T_INSTR, INST_W'($urandom()));
    step(1'b0, T_NOP, '0);

    // interleaved input, nop, instruction while loading
    @(negedge clk);
    do_reset();
    step(1'b1, T_INPUT, INST_W'(32'h3));
    step(1'b1, T_NOP,   INST_W'($urandom()));
    step(1'b1, T_INSTR, INST_W'(32'h7ABCD));
    step(1'b0, T_NOP,   '0);

    // reset right after an instruction is accepted cancels its strobe
    step(1'b1, T_INSTR, INST_W'(32'h12345));
    @(posedge clk);
    #1;
    do_reset();
    step(1'b1, T_INSTR, INST_W'(32'h00abc));
    step(1'b0, T_NOP, '0);

    // saturating drop counter
    @(negedge clk);
    do_reset();
    step(1'b1, T_LAST, INST_W'($urandom()));
    for (int i = 0; i < 300; i++) begin
      rt = 2'($urandom_range(0, 1));
      step(1'b1, rt, INST_W'($urandom()));
    end
    step(1'b0, T_NOP, '0);

    // random mix, including junk above the input index field
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 150; i++) begin
        rt = 2'($urandom_range(0, 3));
        if (rt == T_LAST && $urandom_range(0, 7) != 0) rt = T_INSTR;
        rp = INST_W'($urandom());
        step($urandom_range(0, 3) != 0, rt, rp);
      end
      step(1'b0, T_NOP, '0);
    end

    @(negedge clk);
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nx_node_loader.md
# nx_node_loader

Message decoder that drives the instruction-load and input-load ports of a node core. Accepts a typed message stream from the node's mesh interface, assigns instruction slots sequentially, marks the final instruction, and forwards input-bit updates. Sits between the node message router and the node core, one instance per node.

## Interface

- OP_W, 4, operation encoding width (matches core)
- REG_W, 16, core register count
- IO_W, 4, core primary input/output count
- SLOTS, 32, core instruction slots
- INST_W, OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W), instruction width (19 at defaults)
- MSG_W, INST_W + 2, message width: 2-bit type header plus payload

- clk  input  1  clock; sole clock domain
- rst  input  1  reset; asynchronous, active-high
- msg_data  input  MSG_W  message; [MSG_W-1:MSG_W-2] type, [INST_W-1:0] payload
- msg_valid  input  1  message present
- msg_ready  output  1  message accepted when msg_valid & msg_ready
- load_instr  output  INST_W  instruction to core
- load_slot  output  $clog2(SLOTS)  target slot
- load_last  output  1  final instruction of program
- load_valid  output  1  single-cycle instruction strobe
- in_value  output  1  input bit value
- in_index  output  $clog2(IO_W)  input bit index
- in_valid  output  1  single-cycle input strobe
- loaded  output  1  program complete (state LOADED)
- err  output  1  sticky: a message was dropped
- err_count  output  8  dropped-message count, saturating at 255

## Operation

- Message types: 00 INSTR, 01 INSTR_LAST, 10 INPUT (payload [$clog2(IO_W):1] index, [0] value), 11 NOP.
- States: LOADING (reset) and LOADED. No path back to LOADING except reset.
- LOADING, INSTR: emit instruction at slot counter, load_last=0, counter +1.
- LOADING, INSTR_LAST: emit at slot counter with load_last=1; go LOADED; counter holds.
- Slot overflow: INSTR landing in slot SLOTS-1 is emitted with load_last=1 and moves to LOADED; counter never wraps.
- LOADED, INSTR or INSTR_LAST: dropped, no load_valid; err set, err_count +1.
- INPUT: forwarded in either state; in_index/in_value from payload. Payload bits above index field ignored.
- NOP: accepted, no output, no state change.
- msg_ready = 1 whenever not in reset; loader never back-pressures (core has no ready).
- load_* and in_* are never both valid in one cycle (one message per cycle).

## Timing

- All outputs registered. Message accepted in cycle N -> strobe high in cycle N+1 for exactly one cycle; data fields valid with strobe and hold last value afterwards.
- loaded rises in the cycle load_valid/load_last is presented (N+1), so core and loader enter post-setup together.
- Back-to-back messages: one strobe per cycle, no bubbles.
- Reset values: msg_ready 0 during rst, load_instr 0, load_slot 0, load_last 0, load_valid 0, in_value 0, in_index 0, in_valid 0, loaded 0, err 0, err_count 0; slot counter 0, state LOADING.
- Reset mid-stream: pending strobe cancelled asynchronously; message accepted on the rst-deassert edge is ignored.
- err_count saturates at 255; err stays 1 until reset.

## Configuration

- NX_LOADER_ERR_EN: defined -> err and err_count behave as above. Undefined -> drop logic still discards late instructions, but err and err_count tie to 0 and the counter register is not built.

## Test plan

- Reset, then 3 INSTR (payloads 0x00011, 0x00022, 0x00033) + INSTR_LAST 0x00044 -> load_slot 0,1,2,3 on consecutive cycles, load_last only with slot 3, loaded=1 from that cycle.
- 32 INSTR, no LAST -> slot 31 emitted with load_last=1, loaded=1; 33rd INSTR dropped, err=1, err_count=1.
- After LOADED, INPUT index 2 value 1 then index 2 value 0 -> in_valid two cycles, in_index=2, in_value 1 then 0; no load_valid.
- Interleave INPUT(idx 1, val 1), NOP, INSTR 0x7ABCD in LOADING -> in_valid cycle N+1, nothing N+2, load_valid slot 0 N+3.
- Assert rst one cycle after accepting INSTR -> load_valid never seen; after release slot counter restarts at 0, loaded=0.
- With NX_LOADER_ERR_EN, 300 instructions after LOADED -> err_count=255, err=1; without macro both stay 0.
